wb_port_arbiter: RTL and testbench

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_port_arbiter.sv | 110 +++++++++++
 tb/tb_wb_port_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: shares one register-file write port between the pipeline WB
// stage (fixed priority) and a small FIFO of multi-cycle (mul/div) results.
module wb_port_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  PipeRegWrite,
    input  logic [ADDR_WIDTH-1:0] PipeWriteAddr,
    input  logic [DATA_WIDTH-1:0] PipeWriteData,
    input  logic                  MdValid,
    input  logic [ADDR_WIDTH-1:0] MdAddr,
    input  logic [DATA_WIDTH-1:0] MdData,
    output logic                  MdReady,
    output logic                  RegWrite,
    output logic [ADDR_WIDTH-1:0] WriteAddr,
    output logic [DATA_WIDTH-1:0] WriteData,
    output logic                  Stall,
    output logic                  Pending
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);
    localparam logic [STV_W-1:0] LIMIT = STV_W'(STARVE_LIMIT);

    logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [STV_W-1:0]      starve_cnt;
    logic [STV_W-1:0]      starve_next;
    logic                  stall_q;
    logic                  stall_next;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;

    // Grant logic: the pipeline always wins; the FIFO head drains only in pipe bubbles.
    // Everything is forced quiet while Reset is held, whatever the registers contain.
    always_comb begin
        fifo_empty = (count == '0);
        MdReady    = !Reset && (count != FULL);
        Pending    = !Reset && !fifo_empty;
        Stall      = !Reset && stall_q;
        push       = MdValid && MdReady;
        pop        = !Reset && !PipeRegWrite && !fifo_empty;
        RegWrite   = 1'b0;
        WriteAddr  = '0;
        WriteData  = '0;
        if (!Reset) begin
            if (PipeRegWrite) begin
                RegWrite  = (PipeWriteAddr != '0);
                WriteAddr = PipeWriteAddr;
                WriteData = PipeWriteData;
            end else if (!fifo_empty) begin
                RegWrite  = (addr_mem[rd_ptr] != '0);
                WriteAddr = addr_mem[rd_ptr];
                WriteData = data_mem[rd_ptr];
            end
        end
    end

    // Starvation tracking; Stall rises on the same edge the counter saturates.
    always_comb begin
        starve_next = starve_cnt;
        stall_next  = stall_q;
        if (pop || fifo_empty) begin
            starve_next = '0;
        end else if (starve_cnt != LIMIT) begin
            starve_next = starve_cnt + 1'b1;
        end
        if (pop) begin
            stall_next = 1'b0;
        end else if (starve_next == LIMIT) begin
            stall_next = 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (push) begin
            addr_mem[wr_ptr] <= MdAddr;
            data_mem[wr_ptr] <= MdData;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
            stall_q    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            starve_cnt <= starve_next;
            stall_q    <= stall_next;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized scoreboard bench for wb_port_arbiter: a queue-based reference model predicts
// each cycle's outputs, and a negedge monitor compares them against the DUT.
module tb_wb_port_arbiter;

    localparam int DEPTH        = 2;
    localparam int STARVE_LIMIT = 4;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        PipeRegWrite = 1'b0;
    logic [4:0]  PipeWriteAddr = '0;
    logic [31:0] PipeWriteData = '0;
    logic        MdValid = 1'b0;
    logic [4:0]  MdAddr = '0;
    logic [31:0] MdData = '0;
    logic        MdReady;
    logic        RegWrite;
    logic [4:0]  WriteAddr;
    logic [31:0] WriteData;
    logic        Stall;
    logic        Pending;

    wb_port_arbiter #(
        .DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .Clock(Clock), .Reset(Reset),
        .PipeRegWrite(PipeRegWrite), .PipeWriteAddr(PipeWriteAddr), .PipeWriteData(PipeWriteData),
        .MdValid(MdValid), .MdAddr(MdAddr), .MdData(MdData), .MdReady(MdReady),
        .RegWrite(RegWrite), .WriteAddr(WriteAddr), .WriteData(WriteData),
        .Stall(Stall), .Pending(Pending)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic        rw;
        logic        rdy;
        logic        stall;
        logic        pend;
        logic        chk_ad;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    exp_t exp_q[$];
    ent_t model_q[$];
    int   model_starve = 0;
    bit   model_stall  = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        check1("RegWrite", {31'b0, RegWrite}, {31'b0, e.rw});
        check1("MdReady",  {31'b0, MdReady},  {31'b0, e.rdy});
        check1("Stall",    {31'b0, Stall},    {31'b0, e.stall});
        check1("Pending",  {31'b0, Pending},  {31'b0, e.pend});
        if (e.chk_ad) begin
            check1("WriteAddr", {27'b0, WriteAddr}, {27'b0, e.addr});
            check1("WriteData", WriteData, e.data);
        end
    endtask

    // Drives one cycle of inputs, predicts the outputs from the model, then advances the model
    // to the state it should hold after the coming edge.
    task automatic applyStimulus(input logic rst, input logic prw, input logic [4:0] pa,
                                 input logic [31:0] pd, input logic mv, input logic [4:0] ma,
                                 input logic [31:0] md);
        exp_t e;
        ent_t n;
        int   sz;
        bit   popped;
        @(posedge Clock);
        #1;
        Reset = rst; PipeRegWrite = prw; PipeWriteAddr = pa; PipeWriteData = pd;
        MdValid = mv; MdAddr = ma; MdData = md;
        sz = model_q.size();
        popped = 0;
        e.rw = 0; e.rdy = 0; e.stall = 0; e.pend = 0; e.chk_ad = 1; e.addr = '0; e.data = '0;
        if (rst) begin
            exp_q.push_back(e);
            model_q.delete();
            model_starve = 0;
            model_stall  = 0;
        end else begin
            e.rdy   = (sz != DEPTH);
            e.pend  = (sz != 0);
            e.stall = model_stall;
            if (prw) begin
                e.rw = (pa != 0); e.addr = pa; e.data = pd; e.chk_ad = e.rw;
            end else if (sz > 0) begin
                e.rw = (model_q[0].a != 0); e.addr = model_q[0].a; e.data = model_q[0].d;
                e.chk_ad = e.rw;
                popped = 1;
            end
            exp_q.push_back(e);
            if (popped) void'(model_q.pop_front());
            if (mv && sz != DEPTH) begin
                n.a = ma; n.d = md;
                model_q.push_back(n);
            end
            if (popped || sz == 0) model_starve = 0;
            else if (model_starve < STARVE_LIMIT) model_starve++;
            if (popped) model_stall = 0;
            else if (model_starve == STARVE_LIMIT) model_stall = 1;
        end
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge Clock) begin
        if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end

    initial begin
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 9, 32'h99, 1, 9, 32'h99);
        idle();
        // Pipe-only write, then a lone Md result that appears one cycle later.
        applyStimulus(0, 1, 5, 32'h1234, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 7, 32'hDEAD);
        idle();
        idle();
        // Fill the buffer behind a busy pipe, hold a third offer, starve, then release.
        applyStimulus(0, 1, 1, 32'h11, 1, 2, 32'h22);
        applyStimulus(0, 1, 3, 32'h33, 1, 4, 32'h44);
        for (int i = 0; i < 6; i++) applyStimulus(0, 1, 5'(6 + i), 32'h600 + i, 1, 8, 32'h88);
        applyStimulus(0, 0, 0, 0, 1, 8, 32'h88);
        for (int i = 0; i < 4; i++) idle();
        // Result destined for r0 is dropped but still drains.
        applyStimulus(0, 0, 0, 0, 1, 0, 32'hBEEF);
        idle();
        idle();
        // Reset while full and stalled.
        applyStimulus(0, 1, 2, 32'h2, 1, 10, 32'hA0);
        applyStimulus(0, 1, 3, 32'h3, 1, 11, 32'hB0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 4, 32'h4, 0, 0, 0);
        applyStimulus(1, 1, 4, 32'h4, 1, 12, 32'hC0);
        for (int i = 0; i < 3; i++) idle();
        for (int i = 0; i < 600; i++) begin
            logic [4:0] pa;
            logic [4:0] ma;
            pa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            ma = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            applyStimulus(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 60), pa, $urandom(),
                          ($urandom_range(0, 99) < 50), ma, $urandom());
        end
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge Clock);
        @(negedge Clock);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending expectations expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
